// File: rtl/ws2812_frame_sequencer_if.sv
// Bus between the frame sequencer and its neighbours: frame control, pixel RAM
// read port and the word handoff to the WS2812 bit controller.
interface ws2812_frame_sequencer_if #(
   parameter int ADDR_W = 3
);
   logic              frame_req;
   logic              continuous;
   logic              frame_busy;
   logic              frame_done;
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_rd;
   logic [23:0]       pix_data;
   logic [23:0]       bit_data;
   logic              bit_load;
   logic              bit_done;

   // master is the sequencer: it issues RAM reads and bit-controller loads
   modport master (
      input  frame_req, continuous, pix_data, bit_done,
      output frame_busy, frame_done, pix_addr, pix_rd, bit_data, bit_load
   );

   modport slave (
      output frame_req, continuous, pix_data, bit_done,
      input  frame_busy, frame_done, pix_addr, pix_rd, bit_data, bit_load
   );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// Walks one frame of pixel RAM into the WS2812 bit controller, reordering to wire
// colour order, then holds the line idle for the latch time before flagging done.
module ws2812_frame_sequencer #(
   parameter int F_CLK      = 50_000_000,
   parameter int N_PIXELS   = 8,
   parameter int T_LATCH_US = 80,
   parameter int GRB_ORDER  = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   ws2812_frame_sequencer_if.master bus
);
   localparam int ADDR_W       = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
   localparam int LATCH_CYCLES = F_CLK / 1_000_000 * T_LATCH_US;
   localparam int CNT_W        = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

   localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(N_PIXELS - 1);
   localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  MASK_LAST  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPTURE,
      S_LOAD,
      S_MASK,
      S_SEND,
      S_LATCH
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [23:0]       data_q, data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_q, rd_d;
   logic              load_q, load_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         index_q <= '0;
         addr_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         load_q  <= load_d;
      end
   end

   // Every output is a register, so each one is set on the transition into the
   // state where it must be seen (pix_rd during FETCH, frame_done on return to IDLE).
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      addr_d  = addr_q;
      count_d = count_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      rd_d    = 1'b0;
      load_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.frame_req || bus.continuous) begin
               busy_d  = 1'b1;
               index_d = '0;
               addr_d  = '0;
               rd_d    = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (GRB_ORDER != 0) begin
               data_d = {bus.pix_data[15:8], bus.pix_data[23:16], bus.pix_data[7:0]};
            end else begin
               data_d = bus.pix_data;
            end
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (bus.bit_done) begin
               load_d  = 1'b1;
               count_d = '0;
               state_d = S_MASK;
            end
         end
         // bit_done may still show the previous word's idle level for a cycle or two
         S_MASK: begin
            if (count_q == MASK_LAST) begin
               state_d = S_SEND;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_SEND: begin
            if (bus.bit_done) begin
               if (index_q == LAST_PIX) begin
                  count_d = '0;
                  state_d = S_LATCH;
               end else begin
                  index_d = index_q + 1'b1;
                  addr_d  = index_q + 1'b1;
                  rd_d    = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_LATCH: begin
            if (count_q == LATCH_LAST) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               count_d = '0;
               state_d = S_IDLE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.frame_busy = busy_q;
   assign bus.frame_done = done_q;
   assign bus.pix_addr   = addr_q;
   assign bus.pix_rd     = rd_q;
   assign bus.bit_data   = data_q;
   assign bus.bit_load   = load_q;
endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Scoreboard bench for ws2812_frame_sequencer: a 4-pixel GRB instance driven through
// several frame scenarios, plus a 1-pixel pass-through instance run alongside.
module tb_ws2812_frame_sequencer;
   localparam int N_PIX     = 4;
   localparam int LATCH_EXP = 4000;

   logic clk;
   logic resetn;

   ws2812_frame_sequencer_if #(.ADDR_W(2)) bus ();
   ws2812_frame_sequencer_if #(.ADDR_W(1)) bus2 ();

   ws2812_frame_sequencer #(
      .N_PIXELS (N_PIX)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   ws2812_frame_sequencer #(
      .N_PIXELS  (1),
      .GRB_ORDER (0)
   ) dut_rgb (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus2)
   );

   logic [23:0] mem [N_PIX];
   logic [23:0] exp_data [N_PIX];
   int          addr_q [$];
   logic [23:0] data_q [$];

   int checks        = 0;
   int errors        = 0;
   int cyc           = 0;
   int load_count    = 0;
   int done_count    = 0;
   int done_expected = 0;
   int rise_cycle    = 0;
   int restart_due   = -1;
   int load2_count   = 0;
   int done2_count   = 0;
   int done_delay    = 720;
   bit stall_arm     = 1'b0;
   bit prev_bit_done = 1'b0;
   bit rst_seen      = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Queue the expected RAM reads and loads for n pixels of a frame, then pulse frame_req.
   task automatic applyStimulus(input int n, input bit with_done);
      for (int i = 0; i < n; i++) begin
         addr_q.push_back(i);
         data_q.push_back(exp_data[i]);
      end
      if (with_done) done_expected++;
      bus.frame_req = 1'b1;
      @(posedge clk);
      #1;
      bus.frame_req = 1'b0;
   endtask

   task automatic waitDoneCount(input int target, input int budget);
      int n = 0;
      while (done_count < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (done_count < target) checkOutput("timeout_frame_done", done_count, target);
   endtask

   task automatic waitLoadCount(input int target, input int budget);
      int n = 0;
      while (load_count < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (load_count < target) checkOutput("timeout_bit_load", load_count, target);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #900_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Synchronous pixel RAMs: address seen with pix_rd, data valid the following cycle.
   initial begin : ram_model
      logic       rd;
      logic [1:0] a;
      bus.pix_data = '0;
      forever begin
         @(negedge clk);
         rd = bus.pix_rd;
         a  = bus.pix_addr;
         @(posedge clk);
         #1;
         if (rd) bus.pix_data = mem[a];
      end
   end

   initial begin : ram2_model
      logic rd;
      bus2.pix_data = '0;
      forever begin
         @(negedge clk);
         rd = bus2.pix_rd;
         @(posedge clk);
         #1;
         if (rd) bus2.pix_data = 24'h123456;
      end
   end

   // Bit controller: busy from one cycle after a load until done_delay cycles later;
   // when stall_arm is set, a fetch forces bit_done low for 50 cycles.
   initial begin : bit_ctrl_model
      bus.bit_done = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.bit_load) begin
            @(posedge clk);
            #1;
            bus.bit_done = 1'b0;
            repeat (done_delay) @(posedge clk);
            #1;
            bus.bit_done = 1'b1;
         end else if (stall_arm && bus.pix_rd) begin
            bus.bit_done = 1'b0;
            repeat (50) @(posedge clk);
            #1;
            bus.bit_done = 1'b1;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_seen) begin
            checkOutput("reset_outputs",
                        {bus.frame_busy, bus.frame_done, bus.pix_rd, bus.bit_load,
                         bus.pix_addr, bus.bit_data}, 32'h0);
         end
         rst_seen = !resetn;
         if (cyc == restart_due) begin
            checkOutput("cont_restart_fetch", {bus.pix_rd, bus.pix_addr}, {1'b1, 2'b00});
         end
         if (bus.pix_rd) begin
            if (addr_q.size() == 0) checkOutput("unexpected_pix_rd", bus.pix_rd, 1'b0);
            else checkOutput("pix_addr", bus.pix_addr, addr_q.pop_front());
         end
         if (bus.bit_load) begin
            load_count++;
            checkOutput("load_needs_done", prev_bit_done, 1'b1);
            if (data_q.size() == 0) checkOutput("unexpected_bit_load", bus.bit_load, 1'b0);
            else checkOutput("bit_data", bus.bit_data, data_q.pop_front());
         end
         if (bus.frame_done) begin
            done_count++;
            checkOutput("busy_at_done", bus.frame_busy, 1'b0);
            // latch length counted from the clock edge that samples bit_done high
            checkOutput("latch_latency", cyc - rise_cycle, LATCH_EXP + 1);
            if (done_expected == 0) checkOutput("unexpected_frame_done", bus.frame_done, 1'b0);
            else done_expected--;
            if (bus.continuous) restart_due = cyc + 1;
         end
         if (bus.bit_done && !prev_bit_done) rise_cycle = cyc;
         prev_bit_done = bus.bit_done;
      end
   end

   initial begin : monitor2
      forever begin
         @(negedge clk);
         if (bus2.bit_load) begin
            load2_count++;
            checkOutput("rgb_order_bit_data", bus2.bit_data, 24'h123456);
         end
         if (bus2.frame_done) done2_count++;
      end
   end

   initial begin : stimulus
      int n;
      mem[0] = 24'h112233;
      mem[1] = 24'h445566;
      mem[2] = 24'h778899;
      mem[3] = 24'hAABBCC;
      exp_data[0] = 24'h221133;
      exp_data[1] = 24'h554466;
      exp_data[2] = 24'h887799;
      exp_data[3] = 24'hBBAACC;
      resetn          = 1'b0;
      bus.frame_req   = 1'b0;
      bus.continuous  = 1'b0;
      bus2.frame_req  = 1'b0;
      bus2.continuous = 1'b0;
      bus2.bit_done   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single frame, 720-cycle words, plus pass-through instance");
      bus2.frame_req = 1'b1;
      applyStimulus(N_PIX, 1'b1);
      bus2.frame_req = 1'b0;
      waitDoneCount(1, 10000);

      $display("[TB] continuous mode, three frames");
      done_delay = 20;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N_PIX; i++) begin
            addr_q.push_back(i);
            data_q.push_back(exp_data[i]);
         end
      end
      done_expected += 3;
      bus.continuous = 1'b1;
      waitDoneCount(3, 10000);
      bus.continuous = 1'b0;
      waitDoneCount(4, 6000);
      repeat (50) @(posedge clk);
      #1;

      $display("[TB] stalled bit_done at first load, frame_req pulsed mid-frame");
      stall_arm = 1'b1;
      applyStimulus(N_PIX, 1'b1);
      waitLoadCount(17, 200);
      stall_arm = 1'b0;
      bus.frame_req = 1'b1;
      @(posedge clk);
      #1;
      bus.frame_req = 1'b0;
      waitDoneCount(5, 6000);
      repeat (100) @(posedge clk);
      #1;

      $display("[TB] reset during pixel 2 send");
      applyStimulus(3, 1'b0);
      waitLoadCount(23, 500);
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      n = 0;
      while (!bus.bit_done && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      repeat (4100) @(posedge clk);
      #1;
      applyStimulus(N_PIX, 1'b1);
      waitDoneCount(6, 6000);
      repeat (20) @(posedge clk);
      #1;

      checkOutput("total_bit_loads", load_count, 27);
      checkOutput("total_frame_done", done_count, 6);
      checkOutput("leftover_addr_expect", addr_q.size(), 0);
      checkOutput("leftover_data_expect", data_q.size(), 0);
      checkOutput("leftover_done_expect", done_expected, 0);
      checkOutput("rgb_instance_loads", load2_count, 1);
      checkOutput("rgb_instance_done", done2_count, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Sequences one full LED-strip frame through the WS2812 bit controller: reads N_PIXELS 24-bit RGB words from a synchronous pixel RAM, reorders them to wire colour order and hands each to the bit controller.
- After the last pixel, holds off for the WS2812 latch (reset) time, then reports frame completion.
- Sits between the pattern/framebuffer logic and the bit controller, on the 50 MHz PLL clock domain.

Parameters:
- F_CLK, 50_000_000, clock frequency in Hz.
- N_PIXELS, 8, pixels per frame; must be >= 1.
- T_LATCH_US, 80, idle-low latch time after the last pixel, in microseconds.
- GRB_ORDER, 1, 1 = emit {G,R,B}; 0 = emit pixel word unchanged.
- Localparam ADDR_W = max(1, $clog2(N_PIXELS)).
- Localparam LATCH_CYCLES = F_CLK/1_000_000*T_LATCH_US (4000 at defaults).

Ports:
- clk  in  1  system clock (50 MHz PLL output).
- resetn  in  1  synchronous active-low reset.
- frame_req  in  1  request one frame; sampled only in IDLE.
- continuous  in  1  when 1, restart a new frame automatically after each latch.
- frame_busy  out  1  high from acceptance of a request until frame_done.
- frame_done  out  1  one-cycle pulse at end of latch period.
- pix_addr  out  ADDR_W  pixel RAM read address.
- pix_rd  out  1  pixel RAM read enable; data valid on pix_data the next cycle.
- pix_data  in  24  pixel word {R[23:16], G[15:8], B[7:0]}.
- bit_data  out  24  word to the bit controller, MSB sent first.
- bit_load  out  1  one-cycle pulse; bit controller starts sending bit_data.
- bit_done  in  1  bit controller idle/finished (level).

Behaviour:
- On reset (clk edge with resetn=0): state IDLE; frame_busy=0, frame_done=0, pix_rd=0, bit_load=0, pix_addr=0, bit_data=0, latch counter=0, pixel index=0.
- Reset mid-frame aborts immediately to IDLE. The next frame starts from pixel 0, and no frame_done is issued for the aborted frame.
- IDLE: if frame_req=1 or continuous=1, then frame_busy<=1, index<=0, go to FETCH.
- FETCH: assert pix_rd=1, pix_addr=index (one cycle), go to CAPTURE.
- CAPTURE: register pix_data. If GRB_ORDER, bit_data<={pix_data[15:8],pix_data[23:16],pix_data[7:0]}; otherwise bit_data<=pix_data. Go to LOAD.
- LOAD: if bit_done=1, assert bit_load=1 for one cycle and go to MASK. If bit_done=0, stay in LOAD and hold bit_data.
- MASK: ignore bit_done for 2 cycles, so a stale done level from the previous word is not counted. Then go to SEND.
- SEND: wait for bit_done=1.
  - If index==N_PIXELS-1, go to LATCH with counter<=0.
  - Otherwise index<=index+1 and go to FETCH.
- Inter-pixel gap: 3 cycles (FETCH, CAPTURE, LOAD). This is well under the WS2812 latch threshold, so the frame stays continuous.
- LATCH: counter increments each cycle. At counter==LATCH_CYCLES-1, pulse frame_done=1 and go to IDLE.
  - frame_busy drops in the same cycle that frame_done is high.
  - If continuous=1 at that cycle, IDLE accepts on the next cycle.
- frame_req held high in IDLE starts back-to-back frames. frame_req while busy is ignored and not queued.
- N_PIXELS=1: a single FETCH..SEND pass, then LATCH.
- Index and pix_addr never exceed N_PIXELS-1; there is no wrap within a frame.
- bit_load is never asserted outside LOAD. At most one bit_load per pixel per frame.
- All outputs are registered.

Test Plan:
- Reset, N_PIXELS=4, RAM = 0x112233, 0x445566, 0x778899, 0xAABBCC. Pulse frame_req with a bit_done model that drops 1 cycle after load and returns 720 cycles later.
  - Required: exactly 4 bit_load pulses.
  - bit_data = 0x221133, 0x554466, 0x887799, 0xBBAACC in order.
  - pix_addr = 0, 1, 2, 3.
- Same frame, measure from the last bit_done rising edge: frame_done pulses exactly 4000 cycles later; frame_busy=0 in that same cycle.
- GRB_ORDER=0, pixel 0x123456: bit_data=0x123456.
- continuous held 1 for 3 frames: 3 frame_done pulses, and the next FETCH follows 1 cycle after each frame_done (IDLE cycle). pix_addr restarts at 0 each frame.
- bit_done held 0 for 50 cycles when LOAD is entered: no bit_load until bit_done=1, then exactly one pulse. Also pulse frame_req mid-frame: no extra frame occurs.
- Deassert resetn during pixel 2 SEND: next cycle all outputs are at reset values and no frame_done appears. A fresh frame_req then starts at pix_addr=0.
